branch_redirect_controller: RTL

Sequences the pipeline redirect produced by the branch/jump unit. It latches a resolved taken branch or jump target, steers the PC mux, and holds the PC write until instruction fetch can accept it. It also generates the IF/ID and ID/EX flush pulses that squash wrong-path instructions. It sits between the EX-stage branch/jump unit, the PC register, the instruction-memory interface and the pipeline registers.

---
 rtl/branch_redirect_controller.sv | 99 +++++++++
 1 files changed

// File: rtl/branch_redirect_controller.sv
// Sequences a taken-branch/jump redirect: latches the target, steers the PC mux,
// holds the PC load while fetch is busy and squashes wrong-path instructions.
module branch_redirect_controller #(
   parameter int PC_WIDTH     = 32,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                redirect_req,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                fetch_busy,
   input  logic                stall_in,
   output logic                pc_write,
   output logic                pc_mux_sel,
   output logic [PC_WIDTH-1:0] pc_target,
   output logic                flush_if_id,
   output logic                flush_id_ex,
   output logic                redirect_busy,
   output logic [15:0]         redirect_count
);

   // state      | meaning
   // S_IDLE     | sequential fetch; a redirect_req is accepted here only
   // S_REDIRECT | PC mux on target, both flushes high, waits out fetch_busy
   // S_FLUSH    | extra IF/ID flush cycles after the PC has taken the target
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REDIRECT = 2'd1,
      S_FLUSH    = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [2:0] flush_cnt;
   logic       accept;
   logic       pc_write_raw;

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      pc_write_raw  = 1'b0;
      pc_mux_sel    = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      redirect_busy = 1'b0;
      case (state)
         S_IDLE: begin
            pc_write_raw = ~stall_in & ~fetch_busy;
            if (redirect_req) begin
               accept    = 1'b1;
               state_nxt = S_REDIRECT;
            end
         end
         S_REDIRECT: begin
            // the redirect overrides a load-use stall
            pc_write_raw  = ~fetch_busy;
            pc_mux_sel    = 1'b1;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            redirect_busy = 1'b1;
            if (!fetch_busy)
               state_nxt = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
         end
         S_FLUSH: begin
            pc_write_raw  = ~stall_in & ~fetch_busy;
            flush_if_id   = 1'b1;
            redirect_busy = 1'b1;
            if (flush_cnt == 3'd0)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // keep the PC frozen while reset is held, even in IDLE
   assign pc_write = RESET & pc_write_raw;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= S_IDLE;
         flush_cnt      <= 3'd0;
         pc_target      <= '0;
         redirect_count <= 16'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pc_target <= redirect_pc;
            if (redirect_count != 16'hFFFF)
               redirect_count <= redirect_count + 16'd1;
         end
         if (state == S_REDIRECT && !fetch_busy)
            flush_cnt <= FLUSH_LOAD;
         else if (state == S_FLUSH && flush_cnt != 3'd0)
            flush_cnt <= flush_cnt - 3'd1;
      end
   end

endmodule
